// File: rtl/replay_controller_pkg.sv
// replay_controller_pkg: shared types and sequence arithmetic for the link retry controller
package replay_controller_pkg;
  localparam int PKG_SEQ_W = 4;
  typedef enum logic [1:0] {RUN, HOLD, ERROR} replay_ctrl_state_e;
  typedef struct packed {
    logic link_ready;
    logic tx_enq;
    logic rx_ack_valid;
    logic [PKG_SEQ_W-1:0] rx_ack_seq;
    logic rx_nack_valid;
    logic [PKG_SEQ_W-1:0] rx_nack_seq;
  } replay_ctrl_in_t;
  typedef struct packed {
    logic buf_ready;
    logic buf_ack;
    logic [PKG_SEQ_W-1:0] buf_ack_count;
    logic buf_nack;
  } replay_ctrl_out_t;
  function automatic logic [31:0] seq_dist(input logic [31:0] a, input logic [31:0] b, input int unsigned size);
    return (a - b) & (size - 1);
  endfunction
endpackage

// File: rtl/replay_timer.sv
// replay_timer: ack-progress watchdog; expire pulses on the enabled cycle the count hits TIMEOUT-1
module replay_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  assign expire = enable && cnt == W'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (enable) cnt <= expire ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/replay_controller.sv
// replay_controller: turns partner ACK/NACK and replay timeouts into ReplayBuffer ack/nack controls
module replay_controller
  import replay_controller_pkg::*;
#(
  parameter int BUFFER_SIZE = 16,
  parameter int TIMEOUT = 64,
  parameter int MAX_REPLAY = 4,
  localparam int SEQ_W = $clog2(BUFFER_SIZE),
  localparam int RC_W = $clog2(MAX_REPLAY + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             link_ready,
  input  logic             tx_enq,
  input  logic             rx_ack_valid,
  input  logic [SEQ_W-1:0] rx_ack_seq,
  input  logic             rx_nack_valid,
  input  logic [SEQ_W-1:0] rx_nack_seq,
  output logic             buf_ready,
  output logic             buf_ack,
  output logic [SEQ_W-1:0] buf_ack_count,
  output logic             buf_nack,
  output logic [SEQ_W:0]   outstanding,
  output logic [RC_W-1:0]  replay_count,
  output logic             link_error
);
  replay_ctrl_state_e state, state_n;
  logic [SEQ_W-1:0] tx_seq, tx_n, acked_seq, acked_n, ack_d, nack_d;
  logic [RC_W-1:0] rc_n;
  logic active, ack_acc, nack_ok, progress, timeout, replay_inc, expire;
  assign outstanding = {1'b0, tx_seq - acked_seq};
  assign active = !reset && state != ERROR;
  assign ack_d = SEQ_W'(seq_dist(32'(rx_ack_seq) + 32'd1, 32'(acked_seq), BUFFER_SIZE));
  assign nack_d = SEQ_W'(seq_dist(32'(rx_nack_seq), 32'(acked_seq), BUFFER_SIZE));
  // a valid NACK always wins over an ACK arriving in the same cycle
  assign nack_ok = active && rx_nack_valid && {1'b0, nack_d} <= outstanding;
  assign ack_acc = active && !nack_ok && rx_ack_valid && ack_d != '0 && {1'b0, ack_d} <= outstanding;
  assign progress = ack_acc || (nack_ok && nack_d != '0);
  assign timeout = expire && !nack_ok;
  assign replay_inc = (nack_ok && nack_d == '0) || timeout;
  assign buf_ready = !reset && link_ready && state == RUN;
  assign buf_ack = progress;
  assign buf_ack_count = ack_acc ? ack_d : nack_ok ? nack_d : '0;
  assign buf_nack = nack_ok || timeout;
  assign link_error = state == ERROR;
  replay_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (progress || nack_ok || outstanding == '0),
    .enable(active && state == RUN && outstanding != '0 && !progress),
    .expire(expire)
  );
  always_comb begin
    rc_n = progress ? '0 : replay_inc ? replay_count + 1'b1 : replay_count;
    state_n = (state == ERROR || (replay_inc && rc_n == RC_W'(MAX_REPLAY))) ? ERROR :
              buf_nack ? HOLD : RUN;
    acked_n = acked_seq + buf_ack_count;
    tx_n = nack_ok ? rx_nack_seq : timeout ? acked_seq : (tx_enq && buf_ready) ? tx_seq + 1'b1 : tx_seq;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      tx_seq <= '0;
      acked_seq <= '0;
      replay_count <= '0;
    end else begin
      state <= state_n;
      tx_seq <= tx_n;
      acked_seq <= acked_n;
      replay_count <= rc_n;
    end
  end
  always_ff @(posedge clk) if (!reset && tx_enq) assert (buf_ready);
endmodule

// File: tb/tb_replay_controller.sv
// tb_replay_controller: directed scenario checks for replay_controller
module tb_replay_controller;
  logic clk = 1'b0;
  logic reset, link_ready, tx_enq, rx_ack_valid, rx_nack_valid;
  logic [3:0] rx_ack_seq, rx_nack_seq, buf_ack_count;
  logic buf_ready, buf_ack, buf_nack, link_error;
  logic [4:0] outstanding;
  logic [2:0] replay_count;
  int checks = 0, failures = 0;

  replay_controller dut (
    .clk(clk), .reset(reset), .link_ready(link_ready), .tx_enq(tx_enq),
    .rx_ack_valid(rx_ack_valid), .rx_ack_seq(rx_ack_seq),
    .rx_nack_valid(rx_nack_valid), .rx_nack_seq(rx_nack_seq),
    .buf_ready(buf_ready), .buf_ack(buf_ack), .buf_ack_count(buf_ack_count),
    .buf_nack(buf_nack), .outstanding(outstanding), .replay_count(replay_count),
    .link_error(link_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic enq(input int n);
    for (int i = 0; i < n; i++) begin
      tx_enq = 1'b1;
      tick();
    end
    tx_enq = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    #1;
    checks++;
    if ({buf_ready, buf_ack, buf_nack, link_error} !== 4'b0 || outstanding !== 5'd0 || replay_count !== 3'd0 || buf_ack_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_outputs: ready=%b ack=%b nack=%b err=%b out=%0d rc=%0d cnt=%0d, want all 0", buf_ready, buf_ack, buf_nack, link_error, outstanding, replay_count, buf_ack_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (buf_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", buf_ready); end
    link_ready = 1'b0;
    #1;
    checks++;
    if (buf_ready !== 1'b0) begin failures++; $display("FAIL link_not_ready: got %b want 0", buf_ready); end
    link_ready = 1'b1;
    tick();
  endtask

  task automatic test_ack();
    do_reset();
    enq(5);
    checks++;
    if (outstanding !== 5'd5) begin failures++; $display("FAIL ack_pre_out: got %0d want 5", outstanding); end
    rx_ack_valid = 1'b1; rx_ack_seq = 4'd2;
    #1;
    checks++;
    if (buf_ack !== 1'b1 || buf_ack_count !== 4'd3 || buf_nack !== 1'b0) begin
      failures++; $display("FAIL ack_pulse: ack=%b cnt=%0d nack=%b want 1/3/0", buf_ack, buf_ack_count, buf_nack);
    end
    tick();
    rx_ack_valid = 1'b0;
    #1;
    checks++;
    if (outstanding !== 5'd2 || buf_ack !== 1'b0 || buf_ack_count !== 4'd0) begin
      failures++; $display("FAIL ack_post: out=%0d ack=%b cnt=%0d want 2/0/0", outstanding, buf_ack, buf_ack_count);
    end
  endtask

  task automatic test_nack();
    do_reset();
    enq(6);
    rx_nack_valid = 1'b1; rx_nack_seq = 4'd4;
    #1;
    checks++;
    if (buf_ack !== 1'b1 || buf_ack_count !== 4'd4 || buf_nack !== 1'b1) begin
      failures++; $display("FAIL nack_pulse: ack=%b cnt=%0d nack=%b want 1/4/1", buf_ack, buf_ack_count, buf_nack);
    end
    tick();
    rx_nack_valid = 1'b0;
    #1;
    checks++;
    if (buf_ready !== 1'b0 || outstanding !== 5'd0 || replay_count !== 3'd0 || buf_nack !== 1'b0) begin
      failures++; $display("FAIL nack_hold: ready=%b out=%0d rc=%0d nack=%b want 0/0/0/0", buf_ready, outstanding, replay_count, buf_nack);
    end
    tick();
    checks++;
    if (buf_ready !== 1'b1) begin failures++; $display("FAIL nack_resume: ready=%b want 1", buf_ready); end
  endtask

  task automatic test_timeout();
    int i;
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      enq(3);
      i = 3;
      #1;
      while (!buf_nack && i < 200) begin
        tick();
        i++;
        #1;
      end
      checks++;
      if (buf_nack !== 1'b1 || i != 64) begin
        failures++; $display("FAIL timeout_cycle round %0d: nack=%b at cycle %0d want 1 at 64", r, buf_nack, i);
      end
      tick();
      checks++;
      if (replay_count !== 3'(r) || link_error !== (r == 4) || buf_ready !== 1'b0 || outstanding !== 5'd0) begin
        failures++; $display("FAIL timeout_state round %0d: rc=%0d err=%b ready=%b out=%0d want %0d/%0d/0/0", r, replay_count, link_error, buf_ready, outstanding, r, r == 4);
      end
      if (r < 4) tick();
    end
    rx_nack_valid = 1'b1; rx_nack_seq = 4'd0;
    #1;
    checks++;
    if (buf_nack !== 1'b0) begin failures++; $display("FAIL error_nack_ignored: nack=%b want 0", buf_nack); end
    rx_nack_valid = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    checks++;
    if (link_error !== 1'b1 || buf_ready !== 1'b0) begin
      failures++; $display("FAIL error_sticky: err=%b ready=%b want 1/0", link_error, buf_ready);
    end
    do_reset();
    #1;
    checks++;
    if (link_error !== 1'b0 || buf_ready !== 1'b1 || replay_count !== 3'd0) begin
      failures++; $display("FAIL error_reset: err=%b ready=%b rc=%0d want 0/1/0", link_error, buf_ready, replay_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    enq(14);
    rx_ack_valid = 1'b1; rx_ack_seq = 4'd13;
    tick();
    rx_ack_valid = 1'b0;
    enq(5);
    checks++;
    if (outstanding !== 5'd5) begin failures++; $display("FAIL wrap_out: got %0d want 5", outstanding); end
    rx_ack_valid = 1'b1; rx_ack_seq = 4'd1;
    #1;
    checks++;
    if (buf_ack !== 1'b1 || buf_ack_count !== 4'd4) begin
      failures++; $display("FAIL wrap_ack: ack=%b cnt=%0d want 1/4", buf_ack, buf_ack_count);
    end
    tick();
    #1;
    checks++;
    if (buf_ack !== 1'b0 || buf_ack_count !== 4'd0 || outstanding !== 5'd1) begin
      failures++; $display("FAIL wrap_dup: ack=%b cnt=%0d out=%0d want 0/0/1", buf_ack, buf_ack_count, outstanding);
    end
    tick();
    rx_ack_valid = 1'b0;
    #1;
    checks++;
    if (outstanding !== 5'd1) begin failures++; $display("FAIL wrap_dup_out: got %0d want 1", outstanding); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    enq(4);
    rx_ack_valid = 1'b1; rx_ack_seq = 4'd3;
    rx_nack_valid = 1'b1; rx_nack_seq = 4'd2;
    #1;
    checks++;
    if (buf_ack !== 1'b1 || buf_ack_count !== 4'd2 || buf_nack !== 1'b1) begin
      failures++; $display("FAIL simul_pulse: ack=%b cnt=%0d nack=%b want 1/2/1", buf_ack, buf_ack_count, buf_nack);
    end
    tick();
    rx_ack_valid = 1'b0;
    rx_nack_seq = 4'd3;
    #1;
    checks++;
    if (outstanding !== 5'd0 || buf_nack !== 1'b0 || buf_ack !== 1'b0) begin
      failures++; $display("FAIL nack_beyond: out=%0d nack=%b ack=%b want 0/0/0", outstanding, buf_nack, buf_ack);
    end
    rx_nack_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_hold();
    do_reset();
    enq(4);
    rx_nack_valid = 1'b1; rx_nack_seq = 4'd0;
    tick();
    rx_nack_valid = 1'b0;
    #1;
    checks++;
    if (buf_ready !== 1'b0 || replay_count !== 3'd1 || outstanding !== 5'd0) begin
      failures++; $display("FAIL hold_entry: ready=%b rc=%0d out=%0d want 0/1/0", buf_ready, replay_count, outstanding);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (buf_ready !== 1'b1 || replay_count !== 3'd0 || outstanding !== 5'd0 || {buf_ack, buf_nack, link_error} !== 3'b0) begin
      failures++; $display("FAIL hold_reset: ready=%b rc=%0d out=%0d ack=%b nack=%b err=%b want 1/0/0/0/0/0", buf_ready, replay_count, outstanding, buf_ack, buf_nack, link_error);
    end
  endtask

  initial begin
    reset = 1'b1; link_ready = 1'b1; tx_enq = 1'b0;
    rx_ack_valid = 1'b0; rx_ack_seq = '0; rx_nack_valid = 1'b0; rx_nack_seq = '0;
    tick();
    tick();
    test_reset();
    test_ack();
    test_nack();
    test_timeout();
    test_wrap();
    test_simultaneous();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/replay_controller.md
Name: replay_controller

Overview:
- Sender-side link retry controller that sequences one ReplayBuffer instance.
- Tracks sequence numbers of transmitted packets and turns link-partner ACK/NACK messages into the buffer's ack/ack_count/nack controls.
- Runs a replay timeout and escalates to a sticky link error after repeated failed replays.
- Sits between the link-layer receive decoder and the ReplayBuffer control inputs.

Parameters:
BUFFER_SIZE, 16, ReplayBuffer depth; must be a power of two; SEQ_W = $clog2(BUFFER_SIZE).
TIMEOUT, 64, cycles without ack progress, while packets are outstanding, before a self-initiated replay.
MAX_REPLAY, 4, consecutive replays without forward progress before entering ERROR.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
link_ready  input  1  downstream link can accept a packet this cycle
tx_enq  input  1  ReplayBuffer emitted a packet this cycle (replay_out.enq)
rx_ack_valid  input  1  partner ACK received
rx_ack_seq  input  SEQ_W  ACK: all packets up to and including this seq received
rx_nack_valid  input  1  partner NACK received
rx_nack_seq  input  SEQ_W  NACK: first seq to resend; earlier seqs are implicitly acked
buf_ready  output  1  drives replay_in.ready
buf_ack  output  1  drives replay_in.ack
buf_ack_count  output  SEQ_W  drives replay_in.ack_count
buf_nack  output  1  drives replay_in.nack (rewinds current to tail)
outstanding  output  SEQ_W+1  packets sent but not acked
replay_count  output  $clog2(MAX_REPLAY+1)  consecutive replays without progress
link_error  output  1  sticky; set on entry to ERROR

Behaviour:
- Reset, synchronous active-high: all outputs 0; tx_seq = acked_seq = 0; timer = 0; replay_count = 0; state RUN. Reset asserted mid-replay aborts the replay immediately; the ReplayBuffer is reset by the same signal.
- State registers: tx_seq (next seq to send), acked_seq (oldest unacked seq, equal to the buffer tail), timer, replay_count, state ∈ {RUN, HOLD, ERROR}.
- outstanding = (tx_seq - acked_seq) mod BUFFER_SIZE, zero-extended.
- tx_enq increments tx_seq mod BUFFER_SIZE. tx_enq is only legal while buf_ready = 1; if tx_enq arrives while buf_ready = 0, it is ignored and an assertion fires.
- ACK handling:
  - d = (rx_ack_seq - acked_seq + 1) mod BUFFER_SIZE.
  - Accepted if 1 ≤ d ≤ outstanding: buf_ack = 1, buf_ack_count = d (same-cycle combinational output), acked_seq += d.
  - Otherwise (stale, duplicate or beyond tx_seq) the ACK is dropped and no outputs toggle.
- NACK handling:
  - d = (rx_nack_seq - acked_seq) mod BUFFER_SIZE; must satisfy d ≤ outstanding, else dropped.
  - Accepted: buf_ack = (d != 0), buf_ack_count = d, buf_nack = 1, acked_seq += d, tx_seq = rx_nack_seq.
  - replay_count increments if d == 0; it clears if d > 0.
  - Next state is HOLD.
- Progress: any accepted ACK, or a NACK with d > 0, clears timer and replay_count.
- Timer:
  - Increments each RUN cycle with outstanding > 0 and no progress; held at 0 when outstanding == 0.
  - At timer == TIMEOUT-1 with no progress that cycle: self-NACK (buf_nack = 1, ack_count 0, tx_seq = acked_seq), replay_count++, timer cleared, go to HOLD.
- Simultaneous events:
  - Valid NACK beats ACK; the ACK is dropped that cycle.
  - Accepted ACK beats timeout (timer clears, no replay).
  - tx_enq in the same cycle as NACK/timeout: the rewind wins and tx_seq is set by the rewind.
- HOLD: lasts exactly one cycle, with buf_ready = 0 while the buffer's current pointer rewinds. ACK/NACK are processed normally in HOLD. Next state is RUN, or ERROR per the rule below.
- ERROR: entered when replay_count would reach MAX_REPLAY.
  - link_error = 1 and buf_ready = 0 permanently.
  - ACK/NACK/timer are ignored.
  - Exit only by reset.
- buf_ready = link_ready && state == RUN.
- buf_ack and buf_nack are single-cycle pulses; buf_ack_count is 0 whenever buf_ack = 0.

Decomposition:
- Mesh package gets: typedef ReplayCtrlIn (link_ready, tx_enq, rx_* fields), typedef ReplayCtrlOut (buf_* fields), enum ReplayCtrlState {RUN, HOLD, ERROR}, and function seq_dist(a, b) for the modular difference.
- Top-level ports use the flat list above. An optional packed-struct wrapper maps them onto ReplayBufferIn.
- One natural sub-module: replay_timer (counter, clear, enable, expire pulse at TIMEOUT-1).

Test Plan:
- Reset, then 5 tx_enq, then rx_ack_seq = 2 → buf_ack = 1, buf_ack_count = 3, outstanding 5 → 2, timer cleared.
- acked_seq = 0, tx_seq = 6, rx_nack_seq = 4 → buf_ack = 1, count 4, buf_nack = 1, tx_seq = 4, buf_ready low for exactly 1 cycle, replay_count = 0.
- 3 outstanding, no ACK for 64 cycles → buf_nack pulse at cycle 64, tx_seq = acked_seq, replay_count = 1. Repeat 4 times → link_error = 1, buf_ready stuck at 0 until reset.
- Wrap-around: acked_seq = 14, tx_seq = 3 (outstanding 5), rx_ack_seq = 1 → count 4, acked_seq = 2. Then duplicate rx_ack_seq = 1 → dropped, no buf_ack.
- Same cycle rx_ack_seq = 3 and rx_nack_seq = 2 with acked_seq = 0 → NACK processing only: count 2, buf_nack = 1.
- Reset asserted during HOLD → next cycle all outputs 0, state RUN, outstanding 0.
